// File: rtl/fifo_ctrl_tp_fwft.sv
// FIFO controller for an external two-port RAM with registered read data,
// topped by a 2-entry first-word-fall-through output buffer.
module fifo_ctrl_tp_fwft #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH),
  localparam int BW         = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [AW+1:0]         level,
  output logic                  ram_cen,
  output logic                  ram_wen,
  output logic [BW-1:0]         ram_bwen,
  output logic [AW-1:0]         ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_ren,
  output logic [AW-1:0]         ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  logic [AW-1:0]         wptr_reg;
  logic [AW-1:0]         rptr_reg;
  logic [AW:0]           ram_count_reg;
  logic                  inflight_reg;
  logic [1:0]            buf_count_reg;
  logic                  head_reg;
  logic                  push;
  logic                  pop;
  logic                  ren;
  logic                  tail;
  logic [2:0]            buf_room;
  logic [DATA_WIDTH-1:0] entry [2];

  // Reset gates push so no RAM write can leak out while reset is held.
  assign in_ready  = (ram_count_reg != (AW+1)'(DEPTH));
  assign push      = in_valid & in_ready & ~reset;
  assign out_valid = (buf_count_reg != 2'd0);
  assign pop       = out_valid & out_ready;

  // Occupancy the buffer will have after this cycle's pop, counting the read in flight.
  assign buf_room = {1'b0, buf_count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign ren      = (ram_count_reg != '0) && (buf_room < 3'd2);
  assign tail     = head_reg ^ buf_count_reg[0];

  assign ram_cen   = 1'b1;
  assign ram_bwen  = '1;
  assign ram_wen   = push;
  assign ram_waddr = wptr_reg;
  assign ram_wdata = in_data;
  assign ram_ren   = ren;
  assign ram_raddr = rptr_reg;

  assign out_data = entry[head_reg];
  assign level    = (AW+2)'(ram_count_reg) + (AW+2)'(inflight_reg) + (AW+2)'(buf_count_reg);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      ram_count_reg <= '0;
      inflight_reg  <= 1'b0;
      buf_count_reg <= 2'd0;
      head_reg      <= 1'b0;
    end else begin
      if (push) wptr_reg <= wptr_reg + 1'b1;
      if (ren)  rptr_reg <= rptr_reg + 1'b1;
      if (push && !ren)      ram_count_reg <= ram_count_reg + 1'b1;
      else if (!push && ren) ram_count_reg <= ram_count_reg - 1'b1;
      inflight_reg  <= ren;
      buf_count_reg <= buf_count_reg + {1'b0, inflight_reg} - {1'b0, pop};
      if (pop) head_reg <= ~head_reg;
    end
  end

  // A capture lands behind the current tail; a simultaneous pop only moves the head.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_buf
    logic [DATA_WIDTH-1:0] entry_reg;

    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        entry_reg <= '0;
      else if (inflight_reg && (tail == 1'(gi)))
        entry_reg <= ram_rdata;
    end

    assign entry[gi] = entry_reg;
  end

endmodule

// File: tb/tb_fifo_ctrl_tp_fwft.sv
// Scoreboard bench for fifo_ctrl_tp_fwft with a behavioural two-port RAM
// (registered read data, byte-masked writes).
module tb_fifo_ctrl_tp_fwft;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int BW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW+1:0] level;
  logic          ram_cen, ram_wen, ram_ren;
  logic [BW-1:0] ram_bwen;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pushes = 0;
  int pops = 0;
  int first_pop = -1;
  int last_pop = -1;

  fifo_ctrl_tp_fwft #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_bwen(ram_bwen),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_cen && ram_wen)
      for (int b = 0; b < BW; b++)
        if (ram_bwen[b]) mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
    if (ram_cen && ram_ren) ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Samples at the falling edge, records push/pop transactions, returns at posedge+1.
  task automatic step();
    @(negedge clock);
    cyc++;
    if (in_valid && !in_ready) chk("blocked_wen", 32'(ram_wen), 32'd0);
    if (in_valid && in_ready) begin
      exp_q.push_back(in_data);
      pushes++;
      $display("cyc %0d push %h level %0d", cyc, in_data, level);
    end
    if (out_valid && out_ready) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (exp_q.size() == 0) chk("spurious_pop", 32'(out_valid), 32'd0);
      else begin
        $display("cyc %0d pop %h", cyc, out_data);
        chk("pop_data", out_data, exp_q.pop_front());
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int start, sent, guard, wrap_w, wrap_r;
    logic [AW-1:0] prev_w, prev_r;

    // Reset state, with in_valid high to prove no write escapes.
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ram_wen", 32'(ram_wen), 32'd0);
    chk("rst_ram_ren", 32'(ram_ren), 32'd0);
    chk("rst_ram_cen", 32'(ram_cen), 32'd1);
    in_valid = 1'b0;
    reset = 1'b0;

    // First-word latency.
    in_valid = 1'b1;
    in_data = 32'hA5A5_0001;
    #1;
    chk("lat_c0_wen", 32'(ram_wen), 32'd1);
    chk("lat_c0_waddr", 32'(ram_waddr), 32'd0);
    chk("lat_c0_wdata", ram_wdata, 32'hA5A5_0001);
    chk("lat_c0_bwen", 32'(ram_bwen), 32'hF);
    step();
    in_valid = 1'b0;
    #1;
    chk("lat_c1_ren", 32'(ram_ren), 32'd1);
    chk("lat_c1_raddr", 32'(ram_raddr), 32'd0);
    step();
    #1;
    chk("lat_c2_out_valid", 32'(out_valid), 32'd0);
    step();
    #1;
    chk("lat_c3_out_valid", 32'(out_valid), 32'd1);
    chk("lat_c3_out_data", out_data, 32'hA5A5_0001);
    chk("lat_c3_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    chk("lat_empty_level", 32'(level), 32'd0);

    // Fill to capacity; the last two attempts must be ignored.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    exp_q.delete();
    pushes = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data = 32'(i);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("full_pushes", 32'(pushes), 32'd18);
    chk("full_level", 32'(level), 32'd18);
    chk("full_in_ready", 32'(in_ready), 32'd0);

    // Drain: 18 words back to back.
    out_ready = 1'b1;
    pops = 0;
    first_pop = -1;
    for (int i = 0; i < 18; i++) begin
      #1;
      chk("drain_out_valid", 32'(out_valid), 32'd1);
      step();
    end
    #1;
    chk("drain_pops", 32'(pops), 32'd18);
    chk("drain_gap", 32'(last_pop - first_pop), 32'd17);
    chk("drain_out_valid_end", 32'(out_valid), 32'd0);
    chk("drain_level_end", 32'(level), 32'd0);

    // Streaming: one push and one pop per cycle.
    pops = 0;
    first_pop = -1;
    start = cyc + 1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data = 32'h1000_0000 + 32'(i);
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("stream_pops", 32'(pops), 32'd100);
    chk("stream_first_pop", 32'(first_pop - start), 32'd3);
    chk("stream_last_pop", 32'(last_pop - start), 32'd102);

    // Random stalls across pointer wrap.
    sent = 0;
    guard = 0;
    wrap_w = 0;
    wrap_r = 0;
    prev_w = ram_waddr;
    prev_r = ram_raddr;
    pushes = 0;
    while ((pushes < 40 || exp_q.size() > 0) && guard < 2000) begin
      in_valid = (pushes < 40) && ($urandom_range(0, 3) != 0);
      in_data = 32'hC000_0000 + 32'(pushes);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (ram_wen) begin
        if (ram_waddr < prev_w) wrap_w++;
        prev_w = ram_waddr;
      end
      if (ram_ren) begin
        if (ram_raddr < prev_r) wrap_r++;
        prev_r = ram_raddr;
      end
      step();
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rand_pushes", 32'(pushes), 32'd40);
    chk("rand_left", 32'(exp_q.size()), 32'd0);
    chk("rand_waddr_wrap", 32'(wrap_w > 0), 32'd1);
    chk("rand_raddr_wrap", 32'(wrap_r > 0), 32'd1);

    // Mid-operation reset discards held words and any read in flight.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 32'hBAD0_0000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("mid_level_before", 32'(level), 32'd5);
    reset = 1'b1;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_level", 32'(level), 32'd0);
    chk("mid_out_data", out_data, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    in_valid = 1'b1;
    in_data = 32'h0000_1234;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    pops = 0;
    guard = 0;
    while (pops == 0 && guard < 10) begin
      step();
      guard++;
    end
    chk("mid_popped", 32'(pops), 32'd1);
    #1;
    chk("mid_level_end", 32'(level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
